crc16_link_arbiter: RTL and testbench
=====================================

// Module: crc16_link_arbiter
// PURPOSE
// Round-robin scheduler sharing one serial CRC-16 transmit link among N_REQ
// requesters. Latches the granted requester's 64-bit message and serializes
// it LSB first, then the 16-bit complemented CRC remainder MSB first.
// Sits between message sources and the bit-serial link; a downstream CRC-16
// checker sees standard frames.
// PARAMETERS
// N_REQ   4   number of requesters (2..8)
// MSG_W   64  message bits per frame (fixed 64 in this revision)
// PORTS
// clk        in   1            clock
// rst        in   1            synchronous active-high reset
// en         in   1            bit-time strobe; all state advances only when en=1
// req        in   N_REQ        per-requester request level
// msg_flat   in   N_REQ*MSG_W  requester i message at [i*MSG_W +: MSG_W]
// grant      out  N_REQ        one-hot owner of current frame, 0 when idle
// done       out  N_REQ        one-clk pulse to owner when its frame completes
// busy       out  1            state != IDLE
// ser_out    out  1            serial bit presented this bit time (0 when !ser_valid)
// ser_valid  out  1            high in BODY and REM states
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE; grant, done, busy, ser_out, ser_valid = 0;
//   crc=16'hFFFF; bit counter=0; rr pointer last=N_REQ-1 (req[0] wins first).
// - en=0: every register holds; done not pulsed; outputs static.
// - FSM states: IDLE, BODY, REM, GAP. Transitions only on en=1.
//   IDLE: if |req, pick the first set req scanning last+1, last+2, ... (mod N_REQ);
//     latch its msg, grant<=onehot(winner), last<=winner, crc<=FFFF, cnt<=0 -> BODY.
//     No req: stay IDLE.
//   BODY: ser_out=msg[cnt]. On en: crc update with bit, cnt++; when cnt==MSG_W-1
//     -> REM and rem<=~crc_next (remainder after the final message bit), cnt<=0.
//   REM: ser_out=rem[15]. On en: rem<=rem<<1, cnt++; when cnt==15 -> GAP.
//   GAP: ser_valid=0. On en: done[owner] pulses 1 clk, grant<=0 -> IDLE.
// - CRC update (poly 0x8005, non-reflected): fb=crc[15]^bit;
//   crc_next={crc[14:0],1'b0} ^ (fb ? 16'h8005 : 16'h0000).
// - Frame = 80 ser_valid en-strobes (64 msg + 16 CRC) + 1 GAP strobe.
//   Back-to-back frames are separated by exactly 2 non-valid strobes (GAP, IDLE).
// - Latency: req seen on an IDLE en strobe -> grant and first bit valid next clk.
// - req deassert or msg change mid-frame: ignored (msg latched); frame completes.
// - Owner still requesting at GAP: not favoured; rotation continues from owner+1.
// - rst mid-frame: frame abandoned, no done pulse, full reset values.
// - A CRC-16 checker running the same update from FFFF over all 80 bits ends
//   at residue 16'h800D.
// TESTING
// 1 Single req[2], msg=64'hCAFEBABEDEADBEEF, en=1 always -> grant=4'b0100 next clk;
//   80 valid bits = msg LSB first, then ~crc(msg) MSB first; residue 16'h800D;
//   done[2] after GAP.
// 2 req=4'b1111 held after reset -> grant order 0,1,2,3,0; each frame 80 bits;
//   2 invalid strobes between frames.
// 3 en toggled 1/0 pseudo-randomly plus a 5-clk en=0 hole mid-BODY -> identical
//   bit stream to test 1, outputs frozen while en=0.
// 4 Owner drops req and msg_flat changes at bit 30 -> frame still carries the
//   latched msg with correct CRC; done still pulses.
// 5 rst asserted at REM bit 7 -> next clk grant=0, ser_valid=0, no done;
//   with req=4'b0110 next grant is req[1].
// 6 msg=64'h0 and 64'hFFFF_FFFF_FFFF_FFFF -> CRC bits match reference model;
//   residue 16'h800D.

Source files
------------

// File: rtl/crc16_link_arbiter_if.sv
// Requester-side bundle of the CRC-16 link arbiter:
// strobe, requests, messages and the serial link outputs.
interface crc16_link_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int MSG_W = 64
);
   logic                   en_i;
   logic [N_REQ-1:0]       req_i;
   logic [N_REQ*MSG_W-1:0] msg_flat_i;
   logic [N_REQ-1:0]       grant_o;
   logic [N_REQ-1:0]       done_o;
   logic                   busy_o;
   logic                   ser_out_o;
   logic                   ser_valid_o;

   modport master (
      output en_i, req_i, msg_flat_i,
      input  grant_o, done_o, busy_o,
      input  ser_out_o, ser_valid_o
   );

   modport slave (
      input  en_i, req_i, msg_flat_i,
      output grant_o, done_o, busy_o,
      output ser_out_o, ser_valid_o
   );
endinterface

// File: rtl/crc16_link_arbiter.sv
// Round-robin owner of one bit-serial CRC-16 link: message LSB first,
// then the complemented CRC-16 (poly 0x8005) remainder MSB first.
module crc16_link_arbiter #(
   parameter int N_REQ = 4,
   parameter int MSG_W = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   crc16_link_arbiter_if.slave   link
);
   localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(MSG_W);
   localparam logic [15:0] POLY = 16'h8005;

   typedef enum logic [1:0] {
      IDLE,
      BODY,
      REM,
      GAP
   } state_e;

   state_e           state_q;
   logic [MSG_W-1:0] msg_q;
   logic [15:0]      crc_q;
   logic [15:0]      rem_q;
   logic [CW-1:0]    cnt_q;
   logic [LW-1:0]    last_q;
   logic [N_REQ-1:0] grant_q;
   logic [N_REQ-1:0] done_q;
   logic             ser_out_q;
   logic             ser_valid_q;

   logic [LW-1:0]    win;
   logic             hit;
   int               idx;
   logic [MSG_W-1:0] msg_sel;
   logic [CW-1:0]    cnt_inc;
   logic             fb;
   logic [15:0]      crc_d;

   // Scan far-to-near so the nearest set request after last_q wins.
   always_comb begin
      win = last_q;
      hit = 1'b0;
      idx = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(last_q) + k) % N_REQ;
         if (link.req_i[idx[LW-1:0]]) begin
            win = idx[LW-1:0];
            hit = 1'b1;
         end
      end
   end

   assign msg_sel = link.msg_flat_i[int'(win)*MSG_W +: MSG_W];
   assign cnt_inc = cnt_q + CW'(1);
   assign fb      = crc_q[15] ^ msg_q[cnt_q];
   assign crc_d   = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         msg_q       <= '0;
         crc_q       <= 16'hFFFF;
         rem_q       <= '0;
         cnt_q       <= '0;
         last_q      <= LW'(N_REQ - 1);
         grant_q     <= '0;
         done_q      <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
      end else begin
         done_q <= '0;
         if (link.en_i) begin
            unique case (state_q)
               IDLE: begin
                  if (hit) begin
                     msg_q       <= msg_sel;
                     grant_q     <= N_REQ'(1) << win;
                     last_q      <= win;
                     crc_q       <= 16'hFFFF;
                     cnt_q       <= '0;
                     ser_out_q   <= msg_sel[0];
                     ser_valid_q <= 1'b1;
                     state_q     <= BODY;
                  end
               end
               BODY: begin
                  crc_q <= crc_d;
                  if (cnt_q == CW'(MSG_W - 1)) begin
                     rem_q     <= ~crc_d;
                     ser_out_q <= ~crc_d[15];
                     cnt_q     <= '0;
                     state_q   <= REM;
                  end else begin
                     cnt_q     <= cnt_inc;
                     ser_out_q <= msg_q[cnt_inc];
                  end
               end
               REM: begin
                  rem_q     <= {rem_q[14:0], 1'b0};
                  ser_out_q <= rem_q[14];
                  cnt_q     <= cnt_inc;
                  if (cnt_q == CW'(15)) begin
                     ser_out_q   <= 1'b0;
                     ser_valid_q <= 1'b0;
                     state_q     <= GAP;
                  end
               end
               GAP: begin
                  done_q  <= grant_q;
                  grant_q <= '0;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign link.grant_o     = grant_q;
   assign link.done_o      = done_q;
   assign link.busy_o      = (state_q != IDLE);
   assign link.ser_out_o   = ser_out_q;
   assign link.ser_valid_o = ser_valid_q;
endmodule

// File: tb/tb_crc16_link_arbiter.sv
// Bench for crc16_link_arbiter: vector table, corner sequences and
// randomized round-robin traffic against a division-based CRC model.
module tb_crc16_link_arbiter;
   localparam int N  = 4;
   localparam int MW = 64;

   logic clk = 1'b0;
   logic rst;
   int   en_mode = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   bit   cap_bits[$];
   int   grants[$];
   int   dones[$];
   int   gaps[$];
   int   inv_run = 0;
   bit   seen_v = 1'b0;
   logic [N-1:0] prev_g = '0;

   typedef struct {
      string        nm;
      int           idx;
      logic [63:0]  msg;
      logic [N-1:0] gnt;
      int           mode;
      int           hole;
      int           drop;
   } vec_t;

   always #5 clk = ~clk;

   crc16_link_arbiter_if #(.N_REQ(N), .MSG_W(MW)) lk ();

   crc16_link_arbiter #(.N_REQ(N), .MSG_W(MW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .link  (lk)
   );

   always @(posedge clk) begin
      #1;
      case (en_mode)
         0:       lk.en_i = 1'b1;
         1:       lk.en_i = 1'($urandom_range(0, 1));
         default: lk.en_i = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         inv_run = 0;
         seen_v  = 1'b0;
         prev_g  = '0;
      end else begin
         if (lk.grant_o != '0 && prev_g == '0) grants.push_back(int'(lk.grant_o));
         prev_g = lk.grant_o;
         if (lk.done_o != '0) dones.push_back(int'(lk.done_o));
         if (lk.en_i === 1'b1) begin
            if (lk.ser_valid_o) begin
               cap_bits.push_back(lk.ser_out_o);
               if (seen_v && inv_run > 0) gaps.push_back(inv_run);
               inv_run = 0;
               seen_v  = 1'b1;
            end else begin
               inv_run++;
            end
         end
      end
   end

   // CRC as polynomial long division: init FFFF == first 16 bits inverted.
   function automatic logic [15:0] crc_div(logic [79:0] s, int n);
      logic [95:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[n+15-i] = s[i] ^ (i < 16);
      for (int i = n + 15; i >= 16; i--)
         if (v[i]) v[i-16 +: 17] = v[i-16 +: 17] ^ 17'h18005;
      return v[15:0];
   endfunction

   function automatic logic [79:0] exp_frame(logic [63:0] m);
      logic [79:0] f;
      logic [15:0] c;
      c = crc_div({16'h0, m}, 64);
      f = '0;
      f[63:0] = m;
      for (int j = 0; j < 16; j++) f[64+j] = ~c[15-j];
      return f;
   endfunction

   function automatic int rr_pick(logic [N-1:0] r, int last);
      for (int k = 1; k <= N; k++)
         if (r[(last+k)%N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic int qsz(int w);
      case (w)
         0:       return grants.size();
         1:       return dones.size();
         default: return cap_bits.size();
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_sz(string nm, int w, int n, int budget);
      int t;
      t = 0;
      while (qsz(w) < n && t < budget) begin
         tick();
         t++;
      end
      if (qsz(w) < n) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: timeout, have %0d want %0d", nm, qsz(w), n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      cap_bits.delete();
      grants.delete();
      dones.delete();
      gaps.delete();
   endtask

   task automatic scramble();
      for (int k = 0; k < N * MW / 32; k++) lk.msg_flat_i[k*32 +: 32] = $urandom();
   endtask

   task automatic chk_frame(string nm, logic [63:0] m);
      logic [79:0] got;
      got = '0;
      if (cap_bits.size() < 80) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s bits: got %0d bits expected 80", nm, cap_bits.size());
         return;
      end
      for (int i = 0; i < 80; i++) got[i] = cap_bits.pop_front();
      chk({nm, " bits"}, got, exp_frame(m));
      chk({nm, " residue"}, 80'(crc_div(got, 80)), 80'(16'h800D));
   endtask

   task automatic freeze(string nm, logic [N-1:0] g, logic [79:0] ef);
      int sv;
      logic [2*N+2:0] exp_o;
      logic [2*N+2:0] cur;
      sv = en_mode;
      en_mode = 2;
      tick();
      exp_o = {g, {N{1'b0}}, 1'b1, ef[cap_bits.size()], 1'b1};
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         cur = {lk.grant_o, lk.done_o, lk.busy_o, lk.ser_out_o, lk.ser_valid_o};
         chk({nm, " frozen"}, 80'(cur), 80'(exp_o));
      end
      en_mode = sv;
   endtask

   task automatic run_frame(vec_t v);
      int g0;
      int d0;
      logic [79:0] ef;
      g0 = grants.size();
      d0 = dones.size();
      ef = exp_frame(v.msg);
      cap_bits.delete();
      en_mode = v.mode;
      lk.msg_flat_i[v.idx*MW +: MW] = v.msg;
      lk.req_i = '0;
      lk.req_i[v.idx] = 1'b1;
      wait_sz({v.nm, " grant"}, 0, g0 + 1, 100);
      if (v.drop < 0) lk.req_i = '0;
      if (v.hole >= 0) begin
         wait_sz({v.nm, " hole"}, 2, v.hole, 1000);
         freeze(v.nm, v.gnt, ef);
      end
      if (v.drop >= 0) begin
         wait_sz({v.nm, " drop"}, 2, v.drop, 1000);
         lk.req_i = '0;
         scramble();
      end
      wait_sz({v.nm, " done"}, 1, d0 + 1, 1000);
      repeat (3) tick();
      if (grants.size() > g0) chk({v.nm, " grant"}, 80'(grants[g0]), 80'(v.gnt));
      chk({v.nm, " done pulses"}, 80'(dones.size() - d0), 80'(1));
      if (dones.size() > d0) chk({v.nm, " done owner"}, 80'(dones[d0]), 80'(v.gnt));
      chk_frame(v.nm, v.msg);
      chk({v.nm, " idle"}, 80'(lk.busy_o), 80'(0));
   endtask

   initial begin
      vec_t        tbl[5];
      logic [N-1:0] one;
      logic [N-1:0] pat;
      logic [79:0]  ef;
      logic [63:0]  msgs[N];
      int           last;
      int           w;
      int           g0;
      int           d0;

      one = 1;
      tbl[0] = '{"t1_cafe", 2, 64'hCAFEBABEDEADBEEF, 4'b0100, 0, -1, -1};
      tbl[1] = '{"t6_zero", 0, 64'h0, 4'b0001, 0, -1, -1};
      tbl[2] = '{"t6_ones", 3, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 0, -1, -1};
      tbl[3] = '{"t3_en_hole", 2, 64'hCAFEBABEDEADBEEF, 4'b0100, 1, 20, -1};
      tbl[4] = '{"t4_drop", 1, 64'h0123456789ABCDEF, 4'b0010, 1, -1, 30};

      lk.req_i = '0;
      lk.msg_flat_i = '0;
      do_reset();

      chk("rst grant", 80'(lk.grant_o), 80'(0));
      chk("rst done", 80'(lk.done_o), 80'(0));
      chk("rst busy", 80'(lk.busy_o), 80'(0));
      chk("rst ser_valid", 80'(lk.ser_valid_o), 80'(0));
      chk("rst ser_out", 80'(lk.ser_out_o), 80'(0));
      repeat (3) tick();
      chk("no req stays idle", 80'({lk.busy_o, lk.grant_o}), 80'(0));

      // One IDLE strobe with a request yields grant and first bit next clock.
      ef = exp_frame(64'hCAFEBABEDEADBEEF);
      lk.msg_flat_i[2*MW +: MW] = 64'hCAFEBABEDEADBEEF;
      lk.req_i = 4'b0100;
      tick();
      lk.req_i = '0;
      chk("lat grant", 80'(lk.grant_o), 80'(4'b0100));
      chk("lat valid", 80'(lk.ser_valid_o), 80'(1));
      chk("lat bit0", 80'(lk.ser_out_o), 80'(ef[0]));
      wait_sz("lat done", 1, 1, 200);
      repeat (2) tick();
      chk_frame("lat frame", 64'hCAFEBABEDEADBEEF);

      for (int i = 0; i < 5; i++) run_frame(tbl[i]);

      // All requesting from reset: rotation 0,1,2,3,0 with 2-strobe gaps.
      do_reset();
      en_mode = 0;
      scramble();
      for (int i = 0; i < N; i++) msgs[i] = lk.msg_flat_i[i*MW +: MW];
      lk.req_i = '1;
      wait_sz("t2 grants", 0, 5, 600);
      lk.req_i = '0;
      wait_sz("t2 dones", 1, 5, 200);
      repeat (2) tick();
      last = N - 1;
      for (int k = 0; k < 5; k++) begin
         w = rr_pick('1, last);
         last = w;
         if (grants.size() > k) chk("t2 grant order", 80'(grants[k]), 80'(one << w));
         chk_frame("t2 frame", msgs[w]);
      end
      chk("t2 gap count", 80'(gaps.size()), 80'(4));
      foreach (gaps[k]) chk("t2 gap len", 80'(gaps[k]), 80'(2));

      // Reset at REM bit 7: abandoned frame, pointer back to N-1.
      do_reset();
      en_mode = 0;
      lk.msg_flat_i[0 +: MW] = 64'h5A5A_0F0F_3C3C_9999;
      lk.msg_flat_i[1*MW +: MW] = 64'hDEAD_0000_BEEF_1111;
      lk.req_i = 4'b0001;
      wait_sz("t5 reach rem7", 2, 71, 200);
      chk("t5 pre valid", 80'(lk.ser_valid_o), 80'(1));
      d0 = dones.size();
      rst = 1'b1;
      tick();
      chk("t5 rst grant", 80'(lk.grant_o), 80'(0));
      chk("t5 rst valid", 80'(lk.ser_valid_o), 80'(0));
      chk("t5 rst busy", 80'(lk.busy_o), 80'(0));
      chk("t5 rst done", 80'(lk.done_o), 80'(0));
      rst = 1'b0;
      cap_bits.delete();
      lk.req_i = 4'b0110;
      g0 = grants.size();
      wait_sz("t5 regrant", 0, g0 + 1, 50);
      lk.req_i = '0;
      if (grants.size() > g0) chk("t5 next grant", 80'(grants[g0]), 80'(4'b0010));
      wait_sz("t5 done", 1, d0 + 1, 300);
      repeat (2) tick();
      if (dones.size() > d0) chk("t5 first done", 80'(dones[d0]), 80'(4'b0010));
      chk_frame("t5 frame", 64'hDEAD_0000_BEEF_1111);

      // Randomized request patterns with random en against the model.
      do_reset();
      en_mode = 1;
      last = N - 1;
      for (int r = 0; r < 3; r++) begin
         pat = N'($urandom_range(1, (1 << N) - 1));
         scramble();
         for (int i = 0; i < N; i++) msgs[i] = lk.msg_flat_i[i*MW +: MW];
         cap_bits.delete();
         g0 = grants.size();
         d0 = dones.size();
         lk.req_i = pat;
         wait_sz("rnd grants", 0, g0 + 4, 2000);
         lk.req_i = '0;
         wait_sz("rnd dones", 1, d0 + 4, 1000);
         repeat (3) tick();
         for (int k = 0; k < 4; k++) begin
            w = rr_pick(pat, last);
            last = w;
            if (grants.size() > g0 + k)
               chk("rnd grant", 80'(grants[g0+k]), 80'(one << w));
            if (dones.size() > d0 + k)
               chk("rnd done", 80'(dones[d0+k]), 80'(one << w));
            chk_frame("rnd frame", msgs[w]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
